// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and codes for the multicycle RV32I controller.
// Holds FSM states, opcodes, mux-select codes and the per-state control word.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR_ADR,
    S_JALR_JMP,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       pc_update;
    logic       branch;
    logic       fetch;
    logic       done;
    logic       mem_wait_done;
  } ctrl_t;

  // Moore control word for a state; mem_ready-dependent bits are gated later.
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALR_ADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src       = 1'b1;
        c.result_src    = RES_ALUOUT;
        c.mem_write     = 1'b1;
        c.mem_wait_done = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
        c.done       = 1'b1;
      end
      S_JAL, S_JALR_JMP: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct fields to the ALU operation code.
// Only register-register ops (op[5]=1) may select subtract on funct3=000.
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op5,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    unique case (1'b1)
      alu_op == ALUOP_SUB: code = ALU_SUB;
      alu_op == ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-FSM controller for the multicycle RV32I datapath.
// Control word is registered from next state; handshake gating stays live.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALU_CTRL_W      = 3,
  parameter int MEM_HANDSHAKE   = 1,
  parameter int ENABLE_BNE      = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  reg_write,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            imm_src,
  output logic                  instr_done,
  output logic                  illegal_instr
);

  state_t state;
  state_t state_nxt;
  state_t bad_state;
  ctrl_t  ctl;
  logic   rdy;
  logic   br_ok;
  logic   taken;
  logic   run;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign br_ok = (funct3 == 3'b000) |
                 ((funct3 == 3'b001) & (ENABLE_BNE != 0));
  assign taken = funct3[0] ? ~zero : zero;
  assign bad_state = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op == OP_LOAD:   state_nxt = S_MEMADR;
          op == OP_STORE:  state_nxt = S_MEMADR;
          op == OP_RTYPE:  state_nxt = S_EXECR;
          op == OP_ITYPE:  state_nxt = S_EXECI;
          op == OP_BRANCH: state_nxt = br_ok ? S_BRANCH : bad_state;
          op == OP_JAL:    state_nxt = S_JAL;
          op == OP_JALR:   state_nxt = S_JALR_ADR;
          op == OP_LUI:    state_nxt = S_LUI;
          default:         state_nxt = bad_state;
        endcase
      end
      S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_nxt = S_MEMWB;
      S_MEMWRITE: if (rdy) state_nxt = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: state_nxt = S_FETCH;
      S_EXECR, S_EXECI, S_LUI:    state_nxt = S_ALUWB;
      S_JAL, S_JALR_JMP:          state_nxt = S_ALUWB;
      S_JALR_ADR: state_nxt = S_JALR_JMP;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      ctl           <= ctrl_of(S_FETCH);
      illegal_instr <= 1'b0;
    end else begin
      state <= state_nxt;
      ctl   <= ctrl_of(state_nxt);
      if (state_nxt == S_TRAP) illegal_instr <= 1'b1;
    end
  end

  // Reset must silence every enable in the cycle it is asserted.
  assign run = ~reset;

  assign pc_write   = run & (ctl.pc_update |
                             (ctl.branch & taken) |
                             (ctl.fetch & rdy));
  assign ir_write   = run & ctl.fetch & rdy;
  assign mem_write  = run & ctl.mem_write;
  assign reg_write  = run & ctl.reg_write;
  assign instr_done = run & (ctl.done | (ctl.mem_wait_done & rdy));
  assign adr_src    = ctl.adr_src;
  assign result_src = ctl.result_src;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;

  multicycle_control_unit_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op     (ctl.alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(alu_control)
  );

  always_comb begin
    imm_src = IMM_I;
    unique case (1'b1)
      op == OP_STORE:  imm_src = IMM_S;
      op == OP_BRANCH: imm_src = IMM_B;
      op == OP_JAL:    imm_src = IMM_J;
      op == OP_LUI:    imm_src = IMM_U;
      default:         imm_src = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle controller.
// Second instance runs with BNE disabled to cover the illegal-branch trap.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'h13;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic       instr_done, illegal_instr;

  logic       nb_pc_write, nb_adr_src, nb_mem_write, nb_ir_write;
  logic       nb_reg_write, nb_instr_done, nb_illegal;
  logic [1:0] nb_result_src, nb_alu_src_a, nb_alu_src_b;
  logic [2:0] nb_alu_control, nb_imm_src;

  int checks = 0;
  int errors = 0;

  logic       rw_h[20], mw_h[20], pcw_h[20], irw_h[20], adr_h[20];
  logic [2:0] alu_h[20];
  logic [1:0] rs_h[20], sa_h[20], sb_h[20];
  int         ncyc, ndone;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .alu_control(alu_control),
    .imm_src(imm_src), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  multicycle_control_unit #(.ENABLE_BNE(0)) dut_nb (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(nb_pc_write), .adr_src(nb_adr_src),
    .mem_write(nb_mem_write), .ir_write(nb_ir_write),
    .result_src(nb_result_src), .alu_src_a(nb_alu_src_a),
    .alu_src_b(nb_alu_src_b), .reg_write(nb_reg_write),
    .alu_control(nb_alu_control), .imm_src(nb_imm_src),
    .instr_done(nb_instr_done), .illegal_instr(nb_illegal)
  );

  // Runs one instruction from FETCH, logging outputs per cycle.
  task automatic run_instr(input logic [31:0] ins, input logic z,
                           input int stall_at, input int stalls);
    op = ins[6:0];
    funct3 = ins[14:12];
    funct7b5 = ins[30];
    zero = z;
    ncyc = 0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = !(c >= stall_at && c < stall_at + stalls);
      #1;
      rw_h[c] = reg_write;
      mw_h[c] = mem_write;
      pcw_h[c] = pc_write;
      irw_h[c] = ir_write;
      adr_h[c] = adr_src;
      alu_h[c] = alu_control;
      rs_h[c] = result_src;
      sa_h[c] = alu_src_a;
      sb_h[c] = alu_src_b;
      ncyc = c + 1;
      if (instr_done) begin
        ndone = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  function automatic int ones(input logic h[20], input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(h[i]);
    return s;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_enables got %b want 0000",
               {pc_write, ir_write, mem_write, reg_write});
    end
    checks++;
    if (illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal got %b want 0", illegal_instr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ir_write, pc_write, adr_src} !== 3'b110) begin
      errors++;
      $display("FAIL fetch_en got %b want 110",
               {ir_write, pc_write, adr_src});
    end
    checks++;
    if ({result_src, alu_src_a, alu_src_b} !== 6'b10_00_10) begin
      errors++;
      $display("FAIL fetch_mux got %b want 100010",
               {result_src, alu_src_a, alu_src_b});
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] ins_t[6];
    logic [2:0]  exp_t[6];
    ins_t = '{32'h00000033, 32'h40000033, 32'h00002033,
              32'h00006033, 32'h00007033, 32'h40000013};
    exp_t = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000};
    for (int i = 0; i < 6; i++) begin
      run_instr(ins_t[i], 1'b0, 99, 0);
      checks++;
      if (ncyc !== 4 || ndone !== 1) begin
        errors++;
        $display("FAIL alu_cycles[%0d] got %0d/%0d want 4/1",
                 i, ncyc, ndone);
      end
      checks++;
      if (alu_h[2] !== exp_t[i]) begin
        errors++;
        $display("FAIL alu_ctrl[%0d] got %b want %b",
                 i, alu_h[2], exp_t[i]);
      end
      checks++;
      if (rw_h[3] !== 1'b1 || ones(rw_h, ncyc) != 1) begin
        errors++;
        $display("FAIL alu_regwrite[%0d] got %0d writes want 1 in cyc4",
                 i, ones(rw_h, ncyc));
      end
    end
  endtask

  task automatic test_fetch_stall;
    run_instr(32'h00000033, 1'b0, 0, 2);
    checks++;
    if (ncyc !== 6) begin
      errors++;
      $display("FAIL fetch_stall_cycles got %0d want 6", ncyc);
    end
    checks++;
    if (irw_h[0] !== 1'b0 || pcw_h[1] !== 1'b0 || irw_h[2] !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_gate got %b%b%b want 001",
               irw_h[0], pcw_h[1], irw_h[2]);
    end
  endtask

  task automatic test_lw;
    run_instr(32'h00002003, 1'b0, 3, 2);
    checks++;
    if (ncyc !== 7) begin
      errors++;
      $display("FAIL lw_cycles got %0d want 7", ncyc);
    end
    checks++;
    if (rs_h[6] !== 2'b01 || rw_h[6] !== 1'b1 || ones(rw_h, ncyc) != 1) begin
      errors++;
      $display("FAIL lw_wb got rs=%b rw=%b want rs=01 rw=1",
               rs_h[6], rw_h[6]);
    end
    checks++;
    if (adr_h[4] !== 1'b1 || adr_h[2] !== 1'b0) begin
      errors++;
      $display("FAIL lw_adr got %b%b want 01", adr_h[2], adr_h[4]);
    end
    checks++;
    if (ones(irw_h, ncyc) != 1 || ones(mw_h, ncyc) != 0) begin
      errors++;
      $display("FAIL lw_enables got ir=%0d mw=%0d want 1/0",
               ones(irw_h, ncyc), ones(mw_h, ncyc));
    end
  endtask

  task automatic test_sw;
    run_instr(32'h00002023, 1'b0, 99, 0);
    checks++;
    if (ncyc !== 4 || ndone !== 1) begin
      errors++;
      $display("FAIL sw_cycles got %0d/%0d want 4/1", ncyc, ndone);
    end
    checks++;
    if (mw_h[3] !== 1'b1 || ones(mw_h, ncyc) != 1 || adr_h[3] !== 1'b1) begin
      errors++;
      $display("FAIL sw_memwrite got mw=%0d adr=%b want 1/1",
               ones(mw_h, ncyc), adr_h[3]);
    end
    checks++;
    if (ones(rw_h, ncyc) != 0) begin
      errors++;
      $display("FAIL sw_regwrite got %0d want 0", ones(rw_h, ncyc));
    end
    checks++;
    if (imm_src !== 3'b001) begin
      errors++;
      $display("FAIL sw_imm got %b want 001", imm_src);
    end
    run_instr(32'h00002023, 1'b0, 3, 1);
    checks++;
    if (ncyc !== 5 || ones(mw_h, ncyc) != 2) begin
      errors++;
      $display("FAIL sw_stall got %0d cyc %0d mw want 5/2",
               ncyc, ones(mw_h, ncyc));
    end
  endtask

  task automatic test_branch;
    logic [31:0] ins_t[4];
    logic        z_t[4];
    logic        exp_t[4];
    ins_t = '{32'h00000063, 32'h00000063, 32'h00001063, 32'h00001063};
    z_t   = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_instr(ins_t[i], z_t[i], 99, 0);
      checks++;
      if (ncyc !== 3 || pcw_h[2] !== exp_t[i]) begin
        errors++;
        $display("FAIL branch[%0d] got cyc=%0d pcw=%b want 3/%b",
                 i, ncyc, pcw_h[2], exp_t[i]);
      end
      checks++;
      if (alu_h[2] !== 3'b001 || imm_src !== 3'b010) begin
        errors++;
        $display("FAIL branch_ctl[%0d] got alu=%b imm=%b want 001/010",
                 i, alu_h[2], imm_src);
      end
    end
    checks++;
    if (nb_illegal !== 1'b1 || nb_pc_write !== 1'b0) begin
      errors++;
      $display("FAIL nobne_trap got ill=%b pcw=%b want 1/0",
               nb_illegal, nb_pc_write);
    end
  endtask

  task automatic test_jumps;
    run_instr(32'h0000006F, 1'b0, 99, 0);
    checks++;
    if (ncyc !== 4 || pcw_h[2] !== 1'b1 || rw_h[3] !== 1'b1) begin
      errors++;
      $display("FAIL jal got cyc=%0d pcw=%b rw=%b want 4/1/1",
               ncyc, pcw_h[2], rw_h[3]);
    end
    checks++;
    if (sa_h[2] !== 2'b01 || sb_h[2] !== 2'b10 || imm_src !== 3'b011) begin
      errors++;
      $display("FAIL jal_mux got a=%b b=%b imm=%b want 01/10/011",
               sa_h[2], sb_h[2], imm_src);
    end
    run_instr(32'h00000067, 1'b0, 99, 0);
    checks++;
    if (ncyc !== 5 || pcw_h[2] !== 1'b0 || pcw_h[3] !== 1'b1) begin
      errors++;
      $display("FAIL jalr got cyc=%0d pcw=%b%b want 5/01",
               ncyc, pcw_h[2], pcw_h[3]);
    end
    checks++;
    if (sa_h[2] !== 2'b10 || sb_h[2] !== 2'b01 || imm_src !== 3'b000) begin
      errors++;
      $display("FAIL jalr_mux got a=%b b=%b imm=%b want 10/01/000",
               sa_h[2], sb_h[2], imm_src);
    end
    run_instr(32'h00000037, 1'b0, 99, 0);
    checks++;
    if (ncyc !== 4 || sa_h[2] !== 2'b11 || sb_h[2] !== 2'b01) begin
      errors++;
      $display("FAIL lui got cyc=%0d a=%b b=%b want 4/11/01",
               ncyc, sa_h[2], sb_h[2]);
    end
    checks++;
    if (imm_src !== 3'b100 || rw_h[3] !== 1'b1) begin
      errors++;
      $display("FAIL lui_ctl got imm=%b rw=%b want 100/1",
               imm_src, rw_h[3]);
    end
  endtask

  task automatic test_illegal;
    op = 7'h7F;
    mem_ready = 1'b1;
    zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (illegal_instr !== 1'b1 ||
          {pc_write, ir_write, mem_write, reg_write, instr_done} !== 5'b0) begin
        errors++;
        $display("FAIL trap[%0d] got ill=%b en=%b want 1/00000", i,
                 illegal_instr,
                 {pc_write, ir_write, mem_write, reg_write, instr_done});
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op = 7'h13;
    #1;
    checks++;
    if (illegal_instr !== 1'b0 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL trap_clear got ill=%b irw=%b want 0/1",
               illegal_instr, ir_write);
    end
  endtask

  task automatic test_reset_mid;
    op = 7'h23;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_memwrite got %b want 1", mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got mw=%b done=%b want 0/0",
               mem_write, instr_done);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ir_write !== 1'b1 || mem_write !== 1'b0 || adr_src !== 1'b0) begin
      errors++;
      $display("FAIL mid_refetch got irw=%b mw=%b adr=%b want 1/0/0",
               ir_write, mem_write, adr_src);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_fetch_stall();
    test_lw();
    test_sw();
    test_jumps();
    test_branch();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
